// File: rtl/ps2_keyboard_direction.sv
// ps2_keyboard_direction
//   PS/2 device-to-host receiver plus left/right arrow-key decoder for the
//   street-racing game. Raw PS/2 lines are synchronised and falling edges of
//   PS2_CLK are detected. Eleven-bit frames are assembled and then checked.
//   Each valid byte is shown on LED and toggles KEY_COUNTER. The decoder
//   tracks which direction key is currently held.
//
// Ports
//   CLK          in   system clock, all logic on the rising edge
//   RESET        in   synchronous active-high reset
//   PS2_CLK      in   raw PS/2 clock (asynchronous, idle high)
//   PS2_DATA     in   raw PS/2 data  (asynchronous, idle high)
//   LED          out  last valid received byte (prefix bytes included)
//   LED2         out  direction: 11 = right held, 10 = left held, 00 = none
//   KEY_COUNTER  out  toggles once per valid received byte
//
// Parameters
//   TIMEOUT_CYCLES  CLK cycles without a PS2_CLK fall before a partial frame
//                   is abandoned
//   SYNC_STAGES     synchroniser depth on PS2_CLK / PS2_DATA (>= 2)

module ps2_keyboard_direction #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] LED,
    output logic [1:0] LED2,
    output logic       KEY_COUNTER
);

    localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_prev_reg;
    logic                   ps2_clk_s;
    logic                   ps2_data_s;
    logic                   fall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // Reset to the idle-high level so reset itself never looks like an edge.
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg[0]  <= PS2_CLK;
            data_sync_reg[0] <= PS2_DATA;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_reg[i]  <= clk_sync_reg[i-1];
                data_sync_reg[i] <= data_sync_reg[i-1];
            end
            clk_prev_reg <= ps2_clk_s;
        end
    end

    assign ps2_clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_reg[SYNC_STAGES-1];
    assign fall       = clk_prev_reg & ~ps2_clk_s;

    // ------------------------------------------------------------------
    // Frame assembly and watchdog
    // ------------------------------------------------------------------
    // shift_reg shifts right, so after ten bits:
    //   [0] = start, [8:1] = data byte, [9] = parity.
    // The eleventh (stop) bit is checked directly from the data line.
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    shift_reg;
    logic [TW-1:0] timer_reg;
    logic          frame_done_reg;
    logic [7:0]    frame_byte_reg;
    logic          frame_ok;

    assign frame_ok = ~shift_reg[0] & ps2_data_s & (^shift_reg[9:1]);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            timer_reg      <= '0;
            frame_done_reg <= 1'b0;
            frame_byte_reg <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            if (fall) begin
                timer_reg <= '0;
                if (bit_cnt_reg == 4'd10) begin
                    // Invalid frames just restart the counter; nothing is reported.
                    bit_cnt_reg    <= '0;
                    frame_done_reg <= frame_ok;
                    frame_byte_reg <= shift_reg[8:1];
                end else begin
                    shift_reg   <= {ps2_data_s, shift_reg[9:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else if (bit_cnt_reg != 4'd0) begin
                // A stalled partial frame is dropped so the next fall is a start bit.
                if (timer_reg == TIMEOUT_LAST) begin
                    bit_cnt_reg <= '0;
                    timer_reg   <= '0;
                end else begin
                    timer_reg <= timer_reg + TW'(1);
                end
            end else begin
                timer_reg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder: prefix state (E0 / F0) and held direction
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        PFX_NONE    = 2'b00,
        PFX_EXT     = 2'b01,
        PFX_BRK     = 2'b10,
        PFX_EXT_BRK = 2'b11
    } pfx_t;

    pfx_t       pfx_reg, pfx_next;
    logic [1:0] dir_reg, dir_next;
    logic [7:0] led_reg;
    logic       kc_reg;
    logic       is_ext;
    logic       is_brk;
    logic [1:0] key_code;

    assign is_ext = (pfx_reg == PFX_EXT) || (pfx_reg == PFX_EXT_BRK);
    assign is_brk = (pfx_reg == PFX_BRK) || (pfx_reg == PFX_EXT_BRK);

    always_comb begin
        pfx_next = pfx_reg;
        dir_next = dir_reg;
        key_code = DIR_NONE;

        // Arrow keys only count with E0; the letter keys only without it.
        if (is_ext) begin
            if (frame_byte_reg == 8'h74)      key_code = DIR_RIGHT;
            else if (frame_byte_reg == 8'h6B) key_code = DIR_LEFT;
        end else begin
            if (frame_byte_reg == 8'h23)      key_code = DIR_RIGHT;
            else if (frame_byte_reg == 8'h1C) key_code = DIR_LEFT;
        end

        if (frame_done_reg) begin
            case (frame_byte_reg)
                8'hE0:   pfx_next = is_brk ? PFX_EXT_BRK : PFX_EXT;
                8'hF0:   pfx_next = is_ext ? PFX_EXT_BRK : PFX_BRK;
                default: begin
                    pfx_next = PFX_NONE;
                    if (key_code != DIR_NONE) begin
                        if (is_brk) begin
                            // Only releasing the key that is displayed clears it.
                            if (key_code == dir_reg) dir_next = DIR_NONE;
                        end else begin
                            // Last make wins; a typematic repeat rewrites the same value.
                            dir_next = key_code;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pfx_reg <= PFX_NONE;
            dir_reg <= DIR_NONE;
            led_reg <= '0;
            kc_reg  <= 1'b0;
        end else begin
            pfx_reg <= pfx_next;
            dir_reg <= dir_next;
            if (frame_done_reg) begin
                led_reg <= frame_byte_reg;
                kc_reg  <= ~kc_reg;
            end
        end
    end

    assign LED         = led_reg;
    assign LED2        = dir_reg;
    assign KEY_COUNTER = kc_reg;

endmodule

// File: tb/tb_ps2_keyboard_direction.sv
// Testbench for ps2_keyboard_direction: directed PS/2 frames from a table,
// plus hand-written sequences for latency, watchdog and mid-frame reset.

`timescale 1ns/1ps

module tb_ps2_keyboard_direction;

    localparam int HALF = 20;   // PS/2 half period in CLK cycles
    localparam int IDLE = 40;   // idle CLK cycles after each frame

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] led;
    logic [1:0] led2;
    logic       key_counter;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic exp_kc;

    ps2_keyboard_direction dut (
        .CLK         (clk),
        .RESET       (rst),
        .PS2_CLK     (ps2_clk),
        .PS2_DATA    (ps2_data),
        .LED         (led),
        .LED2        (led2),
        .KEY_COUNTER (key_counter)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       bad;
        logic [7:0] led;
        logic [1:0] dir;
        logic       tog;
    } vec_t;

    vec_t vecs [0:21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Frame bits, index 0 sent first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] mk(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        send_bits(mk(b, bad), 11);
        repeat (IDLE) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_led, input logic [1:0] e_dir);
        check({tag, "_led"}, 32'(led), 32'(e_led));
        check({tag, "_dir"}, 32'(led2), 32'(e_dir));
        check({tag, "_kc"}, 32'(key_counter), 32'(exp_kc));
    endtask

    initial begin
        logic [10:0] bits;
        int          lat;

        vecs[0]  = '{8'hE0, 1'b0, 8'hE0, 2'b10, 1'b1};
        vecs[1]  = '{8'h74, 1'b0, 8'h74, 2'b11, 1'b1};
        vecs[2]  = '{8'hE0, 1'b0, 8'hE0, 2'b11, 1'b1};
        vecs[3]  = '{8'hF0, 1'b0, 8'hF0, 2'b11, 1'b1};
        vecs[4]  = '{8'h74, 1'b0, 8'h74, 2'b00, 1'b1};
        vecs[5]  = '{8'h23, 1'b0, 8'h23, 2'b11, 1'b1};
        vecs[6]  = '{8'h1C, 1'b0, 8'h1C, 2'b10, 1'b1};
        vecs[7]  = '{8'hF0, 1'b0, 8'hF0, 2'b10, 1'b1};
        vecs[8]  = '{8'h23, 1'b0, 8'h23, 2'b10, 1'b1};
        vecs[9]  = '{8'h1C, 1'b0, 8'h1C, 2'b10, 1'b1};
        vecs[10] = '{8'h55, 1'b1, 8'h1C, 2'b10, 1'b0};
        vecs[11] = '{8'h55, 1'b0, 8'h55, 2'b10, 1'b1};
        vecs[12] = '{8'hF0, 1'b0, 8'hF0, 2'b10, 1'b1};
        vecs[13] = '{8'h1C, 1'b0, 8'h1C, 2'b00, 1'b1};
        vecs[14] = '{8'h1C, 1'b1, 8'h1C, 2'b00, 1'b0};
        vecs[15] = '{8'hE0, 1'b0, 8'hE0, 2'b00, 1'b1};
        vecs[16] = '{8'h6B, 1'b0, 8'h6B, 2'b10, 1'b1};
        vecs[17] = '{8'hF0, 1'b0, 8'hF0, 2'b10, 1'b1};
        vecs[18] = '{8'h6B, 1'b0, 8'h6B, 2'b10, 1'b1};
        vecs[19] = '{8'hE0, 1'b0, 8'hE0, 2'b10, 1'b1};
        vecs[20] = '{8'hF0, 1'b0, 8'hF0, 2'b10, 1'b1};
        vecs[21] = '{8'h6B, 1'b0, 8'h6B, 2'b00, 1'b1};

        // Reset held two cycles.
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        exp_kc   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_out("reset", 8'h00, 2'b00);
        $display("txn reset: led=%h dir=%b kc=%b", led, led2, key_counter);

        // First frame 1C with the 11th edge handled by hand to observe latency.
        bits = mk(8'h1C, 1'b0);
        send_bits(bits, 10);
        ps2_data = bits[10];
        repeat (HALF) @(negedge clk);
        check("pre11_led", 32'(led), 32'h00);
        check("pre11_kc", 32'(key_counter), 32'h0);
        ps2_clk = 1'b0;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (lat < 0 && key_counter !== 1'b0) lat = c;
        end
        check("latency_seen", 32'(lat > 0 && lat <= 8), 32'h1);
        ps2_clk = 1'b1;
        repeat (IDLE) @(negedge clk);
        exp_kc = 1'b1;
        check_out("first_1c", 8'h1C, 2'b10);
        $display("txn 1C: latency=%0d led=%h dir=%b kc=%b", lat, led, led2, key_counter);

        // Table-driven frames.
        for (int v = 0; v < 22; v++) begin
            send_byte(vecs[v].code, vecs[v].bad);
            if (vecs[v].tog) exp_kc = ~exp_kc;
            check_out($sformatf("vec%0d", v), vecs[v].led, vecs[v].dir);
            $display("txn vec%0d code=%h bad=%b: led=%h dir=%b kc=%b",
                     v, vecs[v].code, vecs[v].bad, led, led2, key_counter);
        end

        // Ten edges only, then idle past the watchdog, then a valid 23.
        send_bits(mk(8'h1C, 1'b0), 10);
        repeat (5200) @(negedge clk);
        check_out("partial", 8'h6B, 2'b00);
        $display("txn partial+timeout: led=%h dir=%b kc=%b", led, led2, key_counter);
        send_byte(8'h23, 1'b0);
        exp_kc = ~exp_kc;
        check_out("after_timeout", 8'h23, 2'b11);
        $display("txn 23 after timeout: led=%h dir=%b kc=%b", led, led2, key_counter);

        // Reset after five bits, then a full 6B frame.
        send_bits(mk(8'h1C, 1'b0), 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_kc = 1'b0;
        repeat (4) @(negedge clk);
        check_out("midreset", 8'h00, 2'b00);
        $display("txn mid-frame reset: led=%h dir=%b kc=%b", led, led2, key_counter);
        send_byte(8'h6B, 1'b0);
        exp_kc = 1'b1;
        check_out("post_reset_6b", 8'h6B, 2'b00);
        $display("txn 6B after reset: led=%h dir=%b kc=%b", led, led2, key_counter);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
